wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 175 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2
// Function : Two-master Wishbone arbiter with fair (last-served) tie-break and
//            an optional stalled-transfer watchdog (macro WB_ARBITER_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // master 0
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT_CYCLES must lie in 2..65535");
  end

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t r_state;
  logic   r_last;        // 1: m1 was served most recently
  logic   w_abort;
  logic   w_own_cyc;
  logic   w_own_stb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i)
            r_state <= r_last ? OWN0 : OWN1;
          else if (m0_cyc_i)
            r_state <= OWN0;
          else if (m1_cyc_i)
            r_state <= OWN1;
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_o = r_state;

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    case (r_state)
      OWN0: begin
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        s_sel_o   = m0_sel_i;
        s_we_o    = m0_we_i;
        w_own_cyc = m0_cyc_i;
        w_own_stb = m0_stb_i;
      end
      OWN1: begin
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        w_own_cyc = m1_cyc_i;
        w_own_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  assign s_cyc_o  = w_own_cyc & ~w_abort;
  assign s_stb_o  = w_own_stb & ~w_abort;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  // Acks seen while idle or after a timeout belong to nobody.
  assign m0_ack_o = (r_state == OWN0) & s_ack_i & ~w_abort;
  assign m1_ack_o = (r_state == OWN1) & s_ack_i & ~w_abort;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] c_tmo_limit = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_tmo_cnt;
  logic        r_abort;
  logic        w_stall;
  logic        w_hit;

  assign w_stall = s_cyc_o & s_stb_o & ~s_ack_i;
  assign w_hit   = (r_state != IDLE) & ~r_abort & (r_tmo_cnt == c_tmo_limit);

  // After the error pulse the slave side stays released until the owner
  // gives up its cycle; the abort flag clears once back in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_abort   <= 1'b0;
    end else begin
      if (r_state == IDLE || s_ack_i || w_hit)
        r_tmo_cnt <= '0;
      else if (w_stall)
        r_tmo_cnt <= r_tmo_cnt + 16'd1;

      if (r_state == IDLE)
        r_abort <= 1'b0;
      else if (w_hit)
        r_abort <= 1'b1;
    end
  end

  assign w_abort   = r_abort;
  assign timeout_o = w_hit;
  assign m0_err_o  = w_hit & (r_state == OWN0);
  assign m1_err_o  = w_hit & (r_state == OWN1);
`else
  assign w_abort   = 1'b0;
  assign timeout_o = 1'b0;
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter2
// Function : Directed and randomized self-checking bench for wb_arbiter2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (-1 none), who was served last,
  // how long the current owner has been stalled, and whether it was aborted.
  int m_own   = -1;
  int m_last  = 1;
  int m_stall = 0;
  bit m_abort = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tmo_hit();
`ifdef WB_ARBITER_TIMEOUT_EN
    return (m_own >= 0) && !m_abort && (m_stall == TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit own_cyc();
    return (m_own == 0) ? m0_cyc_i : (m_own == 1) ? m1_cyc_i : 1'b0;
  endfunction

  function automatic bit own_stb();
    return (m_own == 0) ? m0_stb_i : (m_own == 1) ? m1_stb_i : 1'b0;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 1; m_stall = 0; m_abort = 1'b0;
  endtask

  task automatic model_edge();
    bit hit;
    hit = tmo_hit();
`ifdef WB_ARBITER_TIMEOUT_EN
    if (m_own < 0 || s_ack_i || hit) m_stall = 0;
    else if (!m_abort && own_cyc() && own_stb()) m_stall++;
    if (m_own < 0) m_abort = 1'b0;
    else if (hit) m_abort = 1'b1;
`endif
    if (m_own < 0) begin
      if (m0_cyc_i && m1_cyc_i) m_own = 1 - m_last;
      else if (m0_cyc_i)        m_own = 0;
      else if (m1_cyc_i)        m_own = 1;
    end else if (!own_cyc()) begin
      m_last = m_own;
      m_own  = -1;
    end
  endtask

  task automatic check_all();
    logic [1:0]  e_grant;
    logic [70:0] e_bus;
    logic [4:0]  e_term;
    bit hit;
    hit     = tmo_hit();
    e_grant = 2'b00;
    e_bus   = '0;
    e_term  = '0;
    if (m_own == 0) begin
      e_grant = 2'b01;
      e_bus   = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i & ~m_abort, m0_stb_i & ~m_abort};
      e_term  = {s_ack_i & ~m_abort, 1'b0, hit, 1'b0, hit};
    end else if (m_own == 1) begin
      e_grant = 2'b10;
      e_bus   = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i & ~m_abort, m1_stb_i & ~m_abort};
      e_term  = {1'b0, s_ack_i & ~m_abort, 1'b0, hit, hit};
    end
    chk("grant", grant_o, e_grant);
    chk("slave_bus", {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o}, e_bus);
    chk("ack_err_tmo", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o}, e_term);
    chk("rdata", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
  endtask

  task automatic look();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic step();
    look();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    int acks;
    reset = 1'b1;
    {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i} = '0;
    {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i} = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_bus_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}, '0);
    chk("rst_term", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o}, 5'b0);
    @(negedge clk);
    reset = 1'b0;

    // m0 alone, single read acked two cycles after stb
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h1000_0040; m0_sel_i = 4'hF;
    look(); chk("r28_lat0", grant_o, 2'b00); tick();
    look(); chk("r28_grant", grant_o, 2'b01); tick();
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    look();
    chk("r28_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    chk("r28_data", m0_dat_o, 32'hDEAD_BEEF);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();

    // Tie right after reset: m0 first, one idle cycle, then m1
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    m1_adr_i = 32'h2000_0000; m1_we_i = 1'b1; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'h3;
    step();
    look(); chk("r29_first", grant_o, 2'b01); tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    look(); chk("r29_idle", grant_o, 2'b00); tick();
    look(); chk("r29_second", grant_o, 2'b10); tick();

    // m1 four-beat burst while m0 waits
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 + i;
      look();
      if (m1_ack_o) acks++;
      chk("r30_hold", {grant_o, m0_ack_o}, {2'b10, 1'b0});
      tick();
      s_ack_i = 1'b0;
      step();
    end
    chk("r30_beats", acks, 4);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    look(); chk("r30_gap", grant_o, 2'b00); tick();
    look(); chk("r30_m0", grant_o, 2'b01); tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();

    // Asynchronous reset while m1 owns the bus
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step();
    look(); chk("r32_own1", grant_o, 2'b10); tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("r32_async", {grant_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o}, 6'b0);
    @(negedge clk);
    reset = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step();
    look(); chk("r32_tie_m0", grant_o, 2'b01); tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step();

    // Stray ack while idle
    s_ack_i = 1'b1;
    look(); chk("r33_idle_ack", {grant_o, m0_ack_o, m1_ack_o}, 4'b0); tick();
    s_ack_i = 1'b0;
    step();

`ifdef WB_ARBITER_TIMEOUT_EN
    // Slave never acks: error pulse TMO cycles after stb, then bus released
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step();
    n = 0;
    while (n <= 20) begin
      look();
      if (timeout_o) break;
      n++;
      tick();
    end
    chk("r31_delay", n, TMO);
    chk("r31_err", {m0_err_o, m1_err_o}, 2'b10);
    tick();
    look();
    chk("r31_release", {s_cyc_o, timeout_o, m0_err_o}, 3'b0);
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 9) != 0);
      else          m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 9) != 0);
      else          m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_ack_i  = ($urandom_range(0, 4) == 0);
      s_dat_i  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
